// File: rtl/cdb_pkg.sv
// Shared types and helpers for the common data bus transmit side.
//   cdb_entry_t        : one buffered FU result {tag, addr, val}
//   rob_age()          : ROB-relative age, wrap-around distance from the ROB head
//   flush_kills()      : true when a tag is younger than the mispredicted branch
//   FIFO_DEPTH_DEFAULT : default per-lane FIFO depth
package cdb_pkg;

  localparam int NUM_OF_FU          = 4;
  localparam int ROB_SIZE_WIDTH     = 4;
  localparam int ARCH_REG_NUM_WIDTH = 5;
  localparam int REG_VAL_WIDTH      = 32;
  localparam int FIFO_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [ROB_SIZE_WIDTH-1:0]     tag;
    logic [ARCH_REG_NUM_WIDTH-1:0] addr;
    logic [REG_VAL_WIDTH-1:0]      val;
  } cdb_entry_t;

  function automatic logic [ROB_SIZE_WIDTH-1:0] rob_age(
    input logic [ROB_SIZE_WIDTH-1:0] tag,
    input logic [ROB_SIZE_WIDTH-1:0] head
  );
    return tag - head;
  endfunction

  // The branch itself and everything older survive.
  function automatic logic flush_kills(
    input logic [ROB_SIZE_WIDTH-1:0] tag,
    input logic [ROB_SIZE_WIDTH-1:0] flush_tag,
    input logic [ROB_SIZE_WIDTH-1:0] head
  );
    return rob_age(tag, head) > rob_age(flush_tag, head);
  endfunction

endpackage

// File: rtl/cdb_if.sv
// Common data bus, one lane per functional unit.
//   valid, inst_tag, register_addr, register_val : indexed by FU lane
//   master modport : cdb_driver
//   slave modport  : ROB / reservation stations
interface CDB_IF;
  import cdb_pkg::*;

  logic [NUM_OF_FU-1:0]                         valid;
  logic [NUM_OF_FU-1:0][ROB_SIZE_WIDTH-1:0]     inst_tag;
  logic [NUM_OF_FU-1:0][ARCH_REG_NUM_WIDTH-1:0] register_addr;
  logic [NUM_OF_FU-1:0][REG_VAL_WIDTH-1:0]      register_val;

  modport master (output valid, inst_tag, register_addr, register_val);
  modport slave  (input  valid, inst_tag, register_addr, register_val);
endinterface

// File: rtl/cdb_lane_fifo.sv
// Per-lane result FIFO with flush-aware compaction.
// Entries are kept head-first at index 0, so a flush simply re-packs the
// survivors in order and the count becomes the survivor count.
//   push/push_entry : accepted FU result (already qualified by ready)
//   bypass_req      : caller allows a direct load of the incoming result
//   flush/flush_tag/rob_head_tag : squash of younger-than-branch entries
//   pop_en          : consumers not stalled
//   ready           : registered count below DEPTH
//   pop/head        : surviving head leaves this cycle
//   bypass          : incoming result goes straight to the output register
module cdb_lane_fifo
  import cdb_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  cdb_entry_t                push_entry,
  input  logic                      bypass_req,
  input  logic                      flush,
  input  logic [ROB_SIZE_WIDTH-1:0] flush_tag,
  input  logic [ROB_SIZE_WIDTH-1:0] rob_head_tag,
  input  logic                      pop_en,
  output logic                      ready,
  output logic                      pop,
  output logic                      bypass,
  output cdb_entry_t                head
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  cdb_entry_t        mem_q [DEPTH];
  cdb_entry_t        mem_d [DEPTH];
  cdb_entry_t        comp  [DEPTH];
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  logic [CW-1:0]     n_surv;
  logic              push_kill;

  assign ready     = count_q < CW'(DEPTH);
  assign push_kill = flush && flush_kills(push_entry.tag, flush_tag, rob_head_tag);
  assign bypass    = bypass_req && push && (count_q == '0) && !push_kill;

  always_comb begin
    n_surv = '0;
    for (int i = 0; i < DEPTH; i++) comp[i] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q && !(flush && flush_kills(mem_q[i].tag, flush_tag, rob_head_tag))) begin
        comp[n_surv[AW-1:0]] = mem_q[i];
        n_surv = n_surv + CW'(1);
      end
    end
  end

  assign pop  = pop_en && (n_surv != '0);
  assign head = comp[0];

  always_comb begin
    count_d = n_surv;
    for (int i = 0; i < DEPTH; i++) mem_d[i] = comp[i];
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = comp[i+1];
      mem_d[DEPTH-1] = '0;
      count_d = n_surv - CW'(1);
    end
    // push implies count_q < DEPTH, so the write slot is always in range
    if (push && !push_kill && !bypass) begin
      mem_d[count_d[AW-1:0]] = push_entry;
      count_d = count_d + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/cdb_driver.sv
// Common data bus transmit side: per-FU valid/ready intake, per-lane FIFO,
// one-cycle valid pulse per broadcast on CDB_IF, branch-flush squash by ROB age.
//   clk, reset (async, active-high)
//   fu_valid/fu_ready, fu_inst_tag, fu_register_addr, fu_register_val : FU results
//   cdb_hold     : consumers stalled, broadcast nothing
//   flush, flush_tag, rob_head_tag : squash of results younger than the branch
//   cdb_if       : CDB_IF.master
// Optional feature macro: CDB_BYPASS_EN (empty-lane results skip the FIFO).
module cdb_driver
  import cdb_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [NUM_OF_FU-1:0]                         fu_valid,
  output logic [NUM_OF_FU-1:0]                         fu_ready,
  input  logic [NUM_OF_FU-1:0][ROB_SIZE_WIDTH-1:0]     fu_inst_tag,
  input  logic [NUM_OF_FU-1:0][ARCH_REG_NUM_WIDTH-1:0] fu_register_addr,
  input  logic [NUM_OF_FU-1:0][REG_VAL_WIDTH-1:0]      fu_register_val,
  input  logic                                         cdb_hold,
  input  logic                                         flush,
  input  logic [ROB_SIZE_WIDTH-1:0]                    flush_tag,
  input  logic [ROB_SIZE_WIDTH-1:0]                    rob_head_tag,
  CDB_IF.master                                        cdb_if
);

  for (genvar g = 0; g < NUM_OF_FU; g++) begin : g_lane
    cdb_entry_t in_entry;
    cdb_entry_t head;
    cdb_entry_t out_q;
    logic       push;
    logic       bypass_req;
    logic       bypass;
    logic       pop;
    logic       valid_q;

    assign in_entry = '{tag: fu_inst_tag[g], addr: fu_register_addr[g], val: fu_register_val[g]};
    assign push     = fu_valid[g] && fu_ready[g];

`ifdef CDB_BYPASS_EN
    assign bypass_req = !cdb_hold;
`else
    assign bypass_req = 1'b0;
`endif

    cdb_lane_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk          (clk),
      .reset        (reset),
      .push         (push),
      .push_entry   (in_entry),
      .bypass_req   (bypass_req),
      .flush        (flush),
      .flush_tag    (flush_tag),
      .rob_head_tag (rob_head_tag),
      .pop_en       (!cdb_hold),
      .ready        (fu_ready[g]),
      .pop          (pop),
      .bypass       (bypass),
      .head         (head)
    );

    // valid is a pure one-cycle pulse per load, so a flush never needs to
    // touch the output register: whatever it holds is never shown again.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        valid_q <= 1'b0;
        out_q   <= '0;
      end else begin
        valid_q <= pop || bypass;
        if (bypass)   out_q <= in_entry;
        else if (pop) out_q <= head;
      end
    end

    assign cdb_if.valid[g]         = valid_q;
    assign cdb_if.inst_tag[g]      = out_q.tag;
    assign cdb_if.register_addr[g] = out_q.addr;
    assign cdb_if.register_val[g]  = out_q.val;
  end

endmodule

// File: tb/tb_cdb_driver.sv
module tb_cdb_driver;
  import cdb_pkg::*;

  localparam int N = NUM_OF_FU;
  localparam int D = FIFO_DEPTH_DEFAULT;
  localparam int R = 1 << ROB_SIZE_WIDTH;
`ifdef CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                                         clk = 1'b0;
  logic                                         reset;
  logic [N-1:0]                                 fu_valid;
  logic [N-1:0]                                 fu_ready;
  logic [N-1:0][ROB_SIZE_WIDTH-1:0]             fu_inst_tag;
  logic [N-1:0][ARCH_REG_NUM_WIDTH-1:0]         fu_register_addr;
  logic [N-1:0][REG_VAL_WIDTH-1:0]              fu_register_val;
  logic                                         cdb_hold;
  logic                                         flush;
  logic [ROB_SIZE_WIDTH-1:0]                    flush_tag;
  logic [ROB_SIZE_WIDTH-1:0]                    rob_head_tag;

  CDB_IF cdb_bus ();

  cdb_driver #(.FIFO_DEPTH(D)) dut (
    .clk              (clk),
    .reset            (reset),
    .fu_valid         (fu_valid),
    .fu_ready         (fu_ready),
    .fu_inst_tag      (fu_inst_tag),
    .fu_register_addr (fu_register_addr),
    .fu_register_val  (fu_register_val),
    .cdb_hold         (cdb_hold),
    .flush            (flush),
    .flush_tag        (flush_tag),
    .rob_head_tag     (rob_head_tag),
    .cdb_if           (cdb_bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  // Reference model: one in-order queue of pending results per lane.
  typedef struct {
    int     tag;
    int     addr;
    longint val;
  } res_t;

  res_t mq [N][$];
  bit   exp_valid [N];
  res_t exp_res   [N];

  function automatic int age(input int t, input int h);
    return (((t - h) % R) + R) % R;
  endfunction

  task automatic model_clear();
    for (int l = 0; l < N; l++) begin
      mq[l].delete();
      exp_valid[l] = 1'b0;
    end
  endtask

  task automatic drive(input int l, input int tag, input int addr, input int val);
    fu_valid[l]         = 1'b1;
    fu_inst_tag[l]      = ROB_SIZE_WIDTH'(tag);
    fu_register_addr[l] = ARCH_REG_NUM_WIDTH'(addr);
    fu_register_val[l]  = REG_VAL_WIDTH'(val);
  endtask

  task automatic idle();
    fu_valid = '0;
    flush    = 1'b0;
  endtask

  // One clock: predict from the current inputs, clock, then compare.
  task automatic cycle();
    res_t keep [$];
    res_t r;
    int   pre_size;
    bit   acc;
    bit   in_kill;
    int   h;
    int   fa;
    h  = int'(rob_head_tag);
    fa = age(int'(flush_tag), h);
    for (int l = 0; l < N; l++)
      check($sformatf("ready%0d", l), 64'(fu_ready[l]), 64'(mq[l].size() < D));
    for (int l = 0; l < N; l++) begin
      pre_size = mq[l].size();
      acc      = fu_valid[l] && (pre_size < D);
      r.tag    = int'(fu_inst_tag[l]);
      r.addr   = int'(fu_register_addr[l]);
      r.val    = longint'(fu_register_val[l]);
      in_kill  = flush && (age(r.tag, h) > fa);
      if (flush) begin
        keep.delete();
        for (int k = 0; k < mq[l].size(); k++)
          if (age(mq[l][k].tag, h) <= fa) keep.push_back(mq[l][k]);
        mq[l] = keep;
      end
      exp_valid[l] = 1'b0;
      if (!cdb_hold && mq[l].size() > 0) begin
        exp_valid[l] = 1'b1;
        exp_res[l]   = mq[l].pop_front();
      end
      if (acc && !in_kill) begin
        if (BYP && pre_size == 0 && !cdb_hold) begin
          exp_valid[l] = 1'b1;
          exp_res[l]   = r;
        end else begin
          mq[l].push_back(r);
        end
      end
    end
    @(posedge clk);
    #1;
    for (int l = 0; l < N; l++) begin
      check($sformatf("valid%0d", l), 64'(cdb_bus.valid[l]), 64'(exp_valid[l]));
      if (exp_valid[l]) begin
        check($sformatf("tag%0d", l),  64'(cdb_bus.inst_tag[l]),      64'(exp_res[l].tag));
        check($sformatf("addr%0d", l), 64'(cdb_bus.register_addr[l]), 64'(exp_res[l].addr));
        check($sformatf("val%0d", l),  64'(cdb_bus.register_val[l]),  64'(exp_res[l].val));
      end
    end
  endtask

  initial begin
    int k;
    bit took;
    reset            = 1'b1;
    fu_valid         = '0;
    fu_inst_tag      = '0;
    fu_register_addr = '0;
    fu_register_val  = '0;
    cdb_hold         = 1'b0;
    flush            = 1'b0;
    flush_tag        = '0;
    rob_head_tag     = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(cdb_bus.valid), 64'(0));
    check("rst_ready", 64'(fu_ready), 64'({N{1'b1}}));
    check("rst_tag",   64'(cdb_bus.inst_tag), 64'(0));
    check("rst_addr",  64'(cdb_bus.register_addr), 64'(0));
    check("rst_val",   64'(|cdb_bus.register_val), 64'(0));
    reset = 1'b0;

    // single result on FU0
    drive(0, 2, 5, 32'h1234);
    cycle();
    check("single_n1", 64'(cdb_bus.valid[0]), 64'(BYP));
    idle();
    cycle();
    check("single_n2", 64'(cdb_bus.valid[0]), 64'(!BYP));
    cycle();
    check("single_off", 64'(cdb_bus.valid), 64'(0));

    // back-pressure on FU1
    cdb_hold = 1'b1;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      took = mq[1].size() < D;
      drive(1, k, k + 1, 32'hB000 + k);
      cycle();
      if (took) k++;
    end
    check("bp_accepts", 64'(k), 64'(4));
    check("bp_ready_low", 64'(fu_ready[1]), 64'(0));
    cdb_hold = 1'b0;
    for (int c = 0; c < 8; c++) begin
      took = (k < 5) && (mq[1].size() < D);
      if (k < 5) drive(1, k, k + 1, 32'hB000 + k);
      else fu_valid[1] = 1'b0;
      cycle();
      if (took) k++;
    end
    check("bp_all", 64'(k), 64'(5));
    idle();

    // flush with tag wrap on lane 2
    rob_head_tag = 4'd14;
    cdb_hold     = 1'b1;
    drive(2, 15, 1, 32'hF15); cycle();
    drive(2, 0,  2, 32'hF00); cycle();
    drive(2, 1,  3, 32'hF01); cycle();
    idle();
    cdb_hold  = 1'b0;
    flush     = 1'b1;
    flush_tag = 4'd0;
    cycle();
    check("wrap_first", 64'(cdb_bus.inst_tag[2]), 64'(15));
    flush = 1'b0;
    cycle();
    check("wrap_second", 64'(cdb_bus.inst_tag[2]), 64'(0));
    cycle();
    check("wrap_killed", 64'(cdb_bus.valid[2]), 64'(0));

    // flush racing an incoming result on FU3
    rob_head_tag = 4'd0;
    flush_tag    = 4'd3;
    flush        = 1'b1;
    drive(3, 7, 9, 32'h7777);
    cycle();
    idle();
    cycle();
    check("race_quiet", 64'(cdb_bus.valid[3]), 64'(0));
    cycle();

    // all lanes on the same edge
    for (int l = 0; l < N; l++) drive(l, l + 8, l + 20, 32'hA0 + l);
    cycle();
    check("par_n1", 64'(cdb_bus.valid), BYP ? 64'({N{1'b1}}) : 64'(0));
    idle();
    cycle();
    check("par_n2", 64'(cdb_bus.valid), BYP ? 64'(0) : 64'({N{1'b1}}));
    cycle();
    check("par_off", 64'(cdb_bus.valid), 64'(0));

    // reset mid-run with 3 entries per lane
    cdb_hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      for (int l = 0; l < N; l++) drive(l, l * 3 + c, c, 32'hC00 + c);
      cycle();
    end
    idle();
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", 64'(cdb_bus.valid), 64'(0));
    check("mid_rst_ready", 64'(fu_ready), 64'({N{1'b1}}));
    model_clear();
    cdb_hold = 1'b0;
    cycle();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) cycle();

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      fu_valid         = N'($urandom);
      for (int l = 0; l < N; l++) begin
        fu_inst_tag[l]      = ROB_SIZE_WIDTH'($urandom_range(0, R - 1));
        fu_register_addr[l] = ARCH_REG_NUM_WIDTH'($urandom);
        fu_register_val[l]  = REG_VAL_WIDTH'($urandom);
      end
      cdb_hold     = ($urandom_range(0, 3) == 0);
      flush        = ($urandom_range(0, 7) == 0);
      flush_tag    = ROB_SIZE_WIDTH'($urandom_range(0, R - 1));
      rob_head_tag = ROB_SIZE_WIDTH'($urandom_range(0, R - 1));
      cycle();
    end
    idle();
    cdb_hold = 1'b0;
    for (int c = 0; c < D + 2; c++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
